// File: rtl/bls_sub_arbiter.sv
// rtl/bls_sub_arbiter.sv - round-robin shared nibble-serial borrow-lookahead subtractor
//
// Purpose: two requesters (A, B) share one 4-bit borrow-lookahead subtract
// stage. An accepted operation computes X - Y - Bin one nibble per clock,
// least-significant nibble first, chaining the borrow between cycles.
// Optional feature macro: BLS_SUB_ARBITER_OVF_EN (adds res_ovf).
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   a_valid / a_ready         requester A handshake (ready is combinational)
//   a_x, a_y, a_bin           requester A minuend, subtrahend, borrow-in
//   b_valid / b_ready         requester B handshake
//   b_x, b_y, b_bin           requester B operands
//   res_valid / res_ready     result handshake toward the consumer
//   res_diff                  X - Y - Bin modulo 2^W
//   res_bout                  final borrow-out (X < Y + Bin, unsigned)
//   res_id                    source of the result: 0 = A, 1 = B
//   res_ovf                   two's-complement overflow (macro only)

module bls_sub_arbiter #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [4*NIBBLES-1:0] a_x,
  input  logic [4*NIBBLES-1:0] a_y,
  input  logic                 a_bin,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [4*NIBBLES-1:0] b_x,
  input  logic [4*NIBBLES-1:0] b_y,
  input  logic                 b_bin,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] res_diff,
  output logic                 res_bout,
  output logic                 res_id
`ifdef BLS_SUB_ARBITER_OVF_EN
  ,
  output logic                 res_ovf
`endif
);

  localparam int W = 4 * NIBBLES;
  localparam logic [2:0] LAST_CNT = 3'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_x;
  logic [W-1:0]   r_y;
  logic [W-1:0]   r_diff;
  logic           r_borrow;
  logic [2:0]     r_cnt;
  logic           r_last;      // 1 = B was granted last
  logic           r_res_valid;
  logic           r_bout;
  logic           r_id;
`ifdef BLS_SUB_ARBITER_OVF_EN
  logic           r_ovf;
`endif

  // Round-robin grant: the non-last requester wins a tie; a lone valid always wins.
  logic w_grant_a;
  logic w_grant_b;
  assign w_grant_a = a_valid & (~b_valid | r_last);
  assign w_grant_b = b_valid & (~a_valid | ~r_last);

  assign a_ready = (r_state == IDLE) & w_grant_a;
  assign b_ready = (r_state == IDLE) & w_grant_b;

  // Operands shift right one nibble per RUN cycle, so the active nibble is
  // always the low four bits.
  logic [3:0] w_xn;
  logic [3:0] w_yn;
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_b;
  logic [3:0] w_dn;

  assign w_xn = r_x[3:0];
  assign w_yn = r_y[3:0];
  assign w_g  = ~w_xn & w_yn;
  assign w_p  = ~(w_xn ^ w_yn);

  // Full lookahead: every internal borrow is a flat sum of products of the
  // nibble generate/propagate terms and the incoming borrow.
  assign w_b[0] = r_borrow;
  assign w_b[1] = w_g[0]
                | (w_p[0] & r_borrow);
  assign w_b[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & r_borrow);
  assign w_b[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & r_borrow);
  assign w_b[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_borrow);

  assign w_dn = ~(w_p ^ w_b[3:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_cnt       <= 3'd0;
      r_last      <= 1'b1;
      r_res_valid <= 1'b0;
      r_bout      <= 1'b0;
      r_id        <= 1'b0;
`ifdef BLS_SUB_ARBITER_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_a | w_grant_b) begin
            r_x      <= w_grant_a ? a_x   : b_x;
            r_y      <= w_grant_a ? a_y   : b_y;
            r_borrow <= w_grant_a ? a_bin : b_bin;
            r_id     <= w_grant_b;
            r_last   <= w_grant_b;
            r_cnt    <= 3'd0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          // Diff nibbles enter at the top and reach their final position
          // after NIBBLES shifts.
          r_diff   <= {w_dn, r_diff[W-1:4]};
          r_x      <= {4'b0000, r_x[W-1:4]};
          r_y      <= {4'b0000, r_y[W-1:4]};
          r_borrow <= w_b[4];
          r_cnt    <= r_cnt + 3'd1;
          if (r_cnt == LAST_CNT) begin
            r_bout      <= w_b[4];
`ifdef BLS_SUB_ARBITER_OVF_EN
            // Borrow into the sign bit differing from the borrow out of it.
            r_ovf       <= w_b[3] ^ w_b[4];
`endif
            r_res_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_diff  = r_diff;
  assign res_bout  = r_bout;
  assign res_id    = r_id;
`ifdef BLS_SUB_ARBITER_OVF_EN
  assign res_ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_bls_sub_arbiter.sv
// tb/tb_bls_sub_arbiter.sv - directed self-checking bench for bls_sub_arbiter

module tb_bls_sub_arbiter;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, a_bin, b_valid, b_bin, res_ready;
  logic [W-1:0] a_x, a_y, b_x, b_y;
  logic         a_ready, b_ready, res_valid, res_bout, res_id;
  logic [W-1:0] res_diff;
`ifdef BLS_SUB_ARBITER_OVF_EN
  logic         res_ovf;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bls_sub_arbiter #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_x       (a_x),
    .a_y       (a_y),
    .a_bin     (a_bin),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_x       (b_x),
    .b_y       (b_y),
    .b_bin     (b_bin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_diff  (res_diff),
    .res_bout  (res_bout),
    .res_id    (res_id)
`ifdef BLS_SUB_ARBITER_OVF_EN
    ,
    .res_ovf   (res_ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Present one operation on the selected requester, wait for its accept and
  // then for res_valid. lat counts clock edges from the accept edge.
  task automatic run_op(input logic sel, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic bin, output logic got, output int lat);
    logic rdy;
    if (!sel) begin a_x = x; a_y = y; a_bin = bin; a_valid = 1'b1; end
    else      begin b_x = x; b_y = y; b_bin = bin; b_valid = 1'b1; end
    #1;
    rdy = sel ? b_ready : a_ready;
    for (int i = 0; i < 10 && !rdy; i++) begin
      step();
      rdy = sel ? b_ready : a_ready;
    end
    step();
    if (!sel) a_valid = 1'b0; else b_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      step();
      lat++;
    end
    got = res_valid;
  endtask

  task automatic test_reset();
    a_valid = 0; b_valid = 0; res_ready = 0;
    a_x = '0; a_y = '0; a_bin = 0; b_x = '0; b_y = '0; b_bin = 0;
    do_reset();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    checks++; if (res_diff !== 16'h0000) begin errors++; $display("FAIL reset_diff got=%h exp=0000", res_diff); end
    checks++; if (res_bout !== 1'b0) begin errors++; $display("FAIL reset_bout got=%b exp=0", res_bout); end
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL reset_id got=%b exp=0", res_id); end
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b%b exp=00", a_ready, b_ready); end
`ifdef BLS_SUB_ARBITER_OVF_EN
    checks++; if (res_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", res_ovf); end
`endif
  endtask

  task automatic test_vectors();
    logic         v_sel  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] v_x    [5] = '{16'h1234, 16'h0000, 16'h8000, 16'h00FF, 16'h0005};
    logic [W-1:0] v_y    [5] = '{16'h0234, 16'h0001, 16'h0000, 16'h0F00, 16'h0005};
    logic         v_bin  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] v_diff [5] = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'hF1FF, 16'hFFFF};
    logic         v_bout [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic         v_ovf  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic got;
    int   lat;
    for (int i = 0; i < 5; i++) begin
      run_op(v_sel[i], v_x[i], v_y[i], v_bin[i], got, lat);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL vec%0d_timeout res_valid=%b exp=1", i, got); end
      checks++; if (lat != NIB) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, NIB); end
      checks++; if (res_diff !== v_diff[i]) begin errors++; $display("FAIL vec%0d_diff got=%h exp=%h", i, res_diff, v_diff[i]); end
      checks++; if (res_bout !== v_bout[i]) begin errors++; $display("FAIL vec%0d_bout got=%b exp=%b", i, res_bout, v_bout[i]); end
      checks++; if (res_id !== v_sel[i]) begin errors++; $display("FAIL vec%0d_id got=%b exp=%b", i, res_id, v_sel[i]); end
`ifdef BLS_SUB_ARBITER_OVF_EN
      checks++; if (res_ovf !== v_ovf[i]) begin errors++; $display("FAIL vec%0d_ovf got=%b exp=%b", i, res_ovf, v_ovf[i]); end
`else
      if (v_ovf[i] === 1'bx) $display("vec%0d ovf reference undefined", i);
`endif
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_release got=%b exp=0", i, res_valid); end
    end
  endtask

  task automatic test_round_robin();
    int grants [4];
    int gcyc   [4];
    int ids    [4];
    logic [W-1:0] diffs [4];
    int ng = 0;
    int nr = 0;
    do_reset();
    a_x = 16'h1234; a_y = 16'h0234; a_bin = 0;
    b_x = 16'h00FF; b_y = 16'h0F00; b_bin = 0;
    a_valid = 1; b_valid = 1; res_ready = 1;
    #1;
    for (int c = 0; c < 60 && (ng < 4 || nr < 4); c++) begin
      if (ng < 4 && (a_ready || b_ready)) begin
        grants[ng] = b_ready ? 1 : 0;
        gcyc[ng]   = cyc;
        ng++;
      end
      if (nr < 4 && res_valid) begin
        ids[nr]   = int'(res_id);
        diffs[nr] = res_diff;
        nr++;
      end
      step();
    end
    a_valid = 0; b_valid = 0; res_ready = 0;
    checks++; if (ng != 4 || nr != 4) begin errors++; $display("FAIL rr_count grants=%0d results=%0d exp=4/4", ng, nr); end
    for (int i = 0; i < 4; i++) begin
      if (i < ng) begin
        checks++; if (grants[i] != i % 2) begin errors++; $display("FAIL rr_grant%0d got=%0d exp=%0d", i, grants[i], i % 2); end
      end
      if (i < nr) begin
        checks++; if (ids[i] != i % 2) begin errors++; $display("FAIL rr_id%0d got=%0d exp=%0d", i, ids[i], i % 2); end
        checks++; if (diffs[i] !== ((i % 2) ? 16'hF1FF : 16'h1000)) begin errors++; $display("FAIL rr_diff%0d got=%h", i, diffs[i]); end
      end
      if (i > 0 && i < ng) begin
        checks++; if (gcyc[i] - gcyc[i-1] != NIB + 2) begin errors++; $display("FAIL rr_spacing%0d got=%0d exp=%0d", i, gcyc[i] - gcyc[i-1], NIB + 2); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic got;
    int   lat;
    do_reset();
    res_ready = 0;
    b_x = 16'h00FF; b_y = 16'h0F00; b_bin = 0; b_valid = 1;
    run_op(1'b0, 16'h8000, 16'h0000, 1'b1, got, lat);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL bp_timeout res_valid=%b exp=1", got); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_diff !== 16'h7FFF || res_bout !== 1'b0 || res_id !== 1'b0 ||
          a_ready !== 1'b0 || b_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b d=%h bo=%b id=%b rdy=%b%b exp v=1 d=7fff bo=0 id=0 rdy=00",
                 i, res_valid, res_diff, res_bout, res_id, a_ready, b_ready);
      end
      step();
    end
    res_ready = 1;
    step();
    res_ready = 0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", res_valid); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL bp_resume got=%b exp=1", b_ready); end
    step();
    b_valid = 0;
    lat = 0;
    while (!res_valid && lat < 20) begin step(); lat++; end
    checks++; if (res_valid !== 1'b1 || res_diff !== 16'hF1FF || res_id !== 1'b1) begin
      errors++; $display("FAIL bp_next got v=%b d=%h id=%b exp v=1 d=f1ff id=1", res_valid, res_diff, res_id);
    end
    res_ready = 1;
    step();
    res_ready = 0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    a_x = 16'h1234; a_y = 16'h0234; a_bin = 0;
    b_x = 16'h00FF; b_y = 16'h0F00; b_bin = 0;
    a_valid = 1; b_valid = 1;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL rm_first_grant got=%b%b exp=10", a_ready, b_ready); end
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b exp=0", res_valid); end
    checks++; if (res_diff !== 16'h0000) begin errors++; $display("FAIL rm_diff got=%h exp=0000", res_diff); end
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL rm_grant got=%b%b exp=10", a_ready, b_ready); end
    a_valid = 0; b_valid = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rm_quiet%0d got=%b exp=0", i, res_valid); end
    end
  endtask

  initial begin
    rst = 1;
    step();
    test_reset();
    test_vectors();
    test_round_robin();
    test_backpressure();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bls_sub_arbiter.md
# bls_sub_arbiter

Sequencing and arbitration controller that shares one 4-bit borrow-lookahead subtract stage between two requesters. It computes wide differences (X − Y − Bin) one nibble per clock, ripple-chaining the borrow between cycles. It sits between two operand sources and a single result consumer, with valid/ready handshakes on every side.

## Interface
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..8
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  requester A has an operation pending
- a_ready  out  1  requester A's operation is accepted this cycle
- a_x, a_y  in  W  requester A minuend and subtrahend
- a_bin  in  1  requester A borrow-in
- b_valid, b_ready, b_x, b_y, b_bin  same as A, for requester B
- res_valid  out  1  result held and valid
- res_ready  in  1  consumer takes the result
- res_diff  out  W  X − Y − Bin, modulo 2^W
- res_bout  out  1  final borrow-out, 1 when X < Y + Bin (unsigned)
- res_id  out  1  source of the result: 0 = A, 1 = B
- res_ovf  out  1  signed overflow; present only with the macro (see Configuration)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Arbitrate round-robin between the asserted valids. Priority pointer `last` resets to B, so A wins first.
  - Assert the winner's ready combinationally, i.e. (state == IDLE) && grant. Ready may depend on valid; valid must not depend on ready.
  - On accept, latch x, y, bin and id, set borrow = bin, cnt = 0, update `last` to the winner, and go to RUN.
- RUN, one nibble per cycle, with i = cnt:
  - G = ~x[i] & y[i]; P = x[i] XNOR y[i].
  - Borrows per bit via full lookahead across the nibble: B0 = borrow, Bk+1 = Gk | Pk·Bk expanded to sum-of-products.
  - Diff bit = P XNOR B.
  - Write diff nibble i, set borrow = nibble borrow-out, cnt++.
  - On cnt == NIBBLES−1, store the final borrow into res_bout and go to DONE.
- DONE:
  - res_valid = 1; res_diff, res_bout, res_id (and res_ovf) are stable.
  - On res_ready, go to IDLE. No accept happens in the same cycle.
- Both ready outputs are 0 in RUN and DONE.
- Arithmetic is exact modulo 2^W; no saturation.

## Timing
- Reset values: state IDLE, res_valid 0, res_diff 0, res_bout 0, res_id 0, res_ovf 0, cnt 0, last = B.
- Latency: with accept at edge k, res_valid rises after edge k+NIBBLES.
- Minimum issue interval is NIBBLES+2 cycles: accept, NIBBLES RUN cycles, one DONE cycle.
- Consumer backpressure: DONE holds indefinitely and outputs do not change.
- Both valids in IDLE: grant goes to the requester that is not `last`. Single valid: that requester wins regardless of `last`.
- A valid deasserted before the accept edge is legal. Nothing is latched for it.
- rst in any state: IDLE on the next edge and all reset values restored. An in-flight result is discarded and no res_valid is produced for it.
- res_valid and res_ready both high at reset assertion: reset wins and the handshake does not complete.

## Configuration
- BLS_SUB_ARBITER_OVF_EN:
  - Defined: port res_ovf exists. It is registered with res_bout as (borrow into bit W−1) XOR (final borrow-out), i.e. two's-complement overflow of X − Y − Bin.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- NIBBLES=4, A only: x=0x1234, y=0x0234, bin=0 → res_diff=0x1000, bout=0, id=0, res_valid exactly 4 cycles after accept.
- Full borrow chain: x=0x0000, y=0x0001, bin=0 → res_diff=0xFFFF, bout=1; ovf=0 with the macro.
- Borrow-in plus overflow: x=0x8000, y=0x0000, bin=1 → res_diff=0x7FFF, bout=0; with the macro, ovf=1.
- Both valids held high, res_ready=1 → res_id sequence 0,1,0,1; grants spaced NIBBLES+2 cycles apart; first grant goes to A after reset.
- res_ready held 0 for 10 cycles in DONE → res_* stable throughout, a_ready = b_ready = 0; accept resumes the cycle after res_ready=1.
- rst pulsed at RUN cycle 2 → IDLE next cycle, res_valid stays 0, next grant goes to A even if B was pending.
